// File: rtl/mult_ctrl_if.sv
// Strobe/handshake bundle between the shift-add multiplier controller and its datapath.
interface mult_ctrl_if;
  logic start;
  logic b0;
  logic clr;
  logic ld;
  logic ldp;
  logic shp;
  logic shb;
  logic busy;
  logic done;

  modport master (
    input  start, b0,
    output clr, ld, ldp, shp, shb, busy, done
  );

  modport slave (
    output start, b0,
    input  clr, ld, ldp, shp, shb, busy, done
  );
endinterface

// File: rtl/mult_ctrl.sv
// Sequencing FSM for the 4-bit shift-add multiplier: clr, ld, then WIDTH add/shift pairs, then done.
// Optional MULT_CTRL_SKIP_ZERO_EN: suppress the ldp strobe when the multiplier LSB (b0) is 0.
module mult_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  mult_ctrl_if.master bus
);

  localparam int unsigned CNTW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              clr_q, ld_q, ldp_q, shp_q, busy_q, done_q;

  // Next state and iteration count; cnt holds at WIDTH-1 on the final shift.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = CLEAR;
      CLEAR: state_d = LOAD;
      LOAD: begin
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD:   state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = ADD;
        end
      end
      DONE:    state_d = bus.start ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the incoming state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      ld_q    <= 1'b0;
      ldp_q   <= 1'b0;
      shp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= (state_d == CLEAR);
      ld_q    <= (state_d == LOAD);
      ldp_q   <= (state_d == ADD);
      shp_q   <= (state_d == SHIFT);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.clr  = clr_q;
  assign bus.ld   = ld_q;
  assign bus.shp  = shp_q;
  assign bus.shb  = shp_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef MULT_CTRL_SKIP_ZERO_EN
  // b0 reflects MB during the ADD cycle itself, so the gate must be combinational.
  assign bus.ldp = ldp_q & bus.b0;
`else
  logic unused_b0;
  assign unused_b0 = bus.b0;
  assign bus.ldp   = ldp_q;
`endif

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a behavioural shift-add datapath (MA/MB/product) model.
module tb_mult_ctrl;

  logic clk = 1'b0;
  logic clr_n;
  int   total = 0;
  int   bad   = 0;

  mult_ctrl_if bus();

  mult_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Datapath model driven by the DUT strobes.
  logic [3:0] da, db;
  logic [3:0] ma_m, mb_m;
  logic [8:0] acc_m;

  assign bus.b0 = mb_m[0];

  always @(posedge clk) begin
    if (bus.clr) begin
      ma_m  <= '0;
      mb_m  <= '0;
      acc_m <= '0;
    end else if (bus.ld) begin
      ma_m <= da;
      mb_m <= db;
    end else begin
      if (bus.ldp) acc_m[8:4] <= {1'b0, acc_m[7:4]} + {1'b0, (mb_m[0] ? ma_m : 4'd0)};
      if (bus.shp) acc_m <= acc_m >> 1;
      if (bus.shb) mb_m  <= mb_m >> 1;
    end
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] outs();
    return {2'b00, bus.clr, bus.ld, bus.ldp, bus.shp, bus.shb, bus.busy, bus.done};
  endfunction

  // Strobe exclusivity and shb/shp pairing, checked every cycle out of reset.
  always @(negedge clk) begin
    if (clr_n === 1'b1) begin
      chk("onehot", 9'(int'(bus.clr) + int'(bus.ld) + int'(bus.ldp) + int'(bus.shp) > 1), 9'd0);
      chk("shb_eq_shp", 9'(bus.shb), 9'(bus.shp));
    end
  end

  // One complete operation from a single start pulse.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_p, input int exp_ldp);
    int cyc, n_ldp, n_sh;
    da = a;
    db = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("clr_k1", 9'(bus.clr), 9'd1);
    chk("busy_k1", 9'(bus.busy), 9'd1);
    step();
    chk("ld_k2", 9'(bus.ld), 9'd1);
    cyc = 2; n_ldp = 0; n_sh = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
      if (bus.ldp === 1'b1) n_ldp++;
      if (bus.shp === 1'b1) n_sh++;
    end
    chk("done_latency", 9'(cyc), 9'd11);
    chk("ldp_count", 9'(n_ldp), 9'(exp_ldp));
    chk("shp_count", 9'(n_sh), 9'd4);
    chk("product", 9'(acc_m[7:0]), 9'(exp_p));
    step();
    chk("done_pulse", 9'(bus.done), 9'd0);
    chk("busy_after", 9'(bus.busy), 9'd0);
  endtask

  function automatic int exp_adds(input logic [3:0] b);
`ifdef MULT_CTRL_SKIP_ZERO_EN
    return $countones(b);
`else
    return (b == b) ? 4 : 0;
`endif
  endfunction

  initial begin
    int cyc;
    clr_n     = 1'b0;
    bus.start = 1'b0;
    da        = '0;
    db        = '0;

    // Reset and idle
    #2;
    chk("reset_outs", outs(), 9'd0);
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_outs", outs(), 9'd0);
    end

    // Basic products and zero operands
    run_op(4'd13, 4'd11, 8'd143, exp_adds(4'd11));
    run_op(4'd0,  4'd15, 8'd0,   exp_adds(4'd15));
    run_op(4'd15, 4'd0,  8'd0,   exp_adds(4'd0));

    // Back-to-back with start held high
    da = 4'd13;
    db = 4'd11;
    bus.start = 1'b1;
    step();
    chk("b2b_first_clr", 9'(bus.clr), 9'd1);
    for (int op = 0; op < 3; op++) begin
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 40) begin
        step();
        cyc++;
      end
      chk("b2b_period", 9'(cyc), 9'd11);
      chk("b2b_product", 9'(acc_m[7:0]), 9'd143);
      step();
      chk("b2b_clr_after_done", 9'(bus.clr), 9'd1);
      chk("b2b_busy_after_done", 9'(bus.busy), 9'd1);
    end
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy !== 1'b0 && cyc < 40) begin
      step();
      cyc++;
    end
    chk("b2b_drain_idle", 9'(bus.busy), 9'd0);

    // Asynchronous reset during the second ADD
    da = 4'd13;
    db = 4'd11;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    chk("second_add_ldp", 9'(bus.ldp), 9'd1);
    clr_n = 1'b0;
    #1;
    chk("midop_reset_outs", outs(), 9'd0);
    @(negedge clk);
    clr_n = 1'b1;
    step();
    chk("post_reset_idle", outs(), 9'd0);
    run_op(4'd7, 4'd9, 8'd63, exp_adds(4'd9));

    // Sparse multiplier
    run_op(4'd15, 4'd5, 8'd75, exp_adds(4'd5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
